// File: rtl/imem_fetch_arb.sv
// Instruction ROM arbiter between the CPU fetch port and a debug/loader port.
// One ROM access per cycle; debug wins a tie after MAX_WAIT lost rounds.
module imem_fetch_arb #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_ready,
  output logic [63:0] cpu_inst,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_ready,
  output logic [63:0] dbg_inst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [63:0] rom_inst
);

  localparam logic [3:0] WaitMax = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    ACC_CPU,
    ACC_DBG
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       cpu_elig;
  logic       dbg_elig;
  logic       cpu_win;
  logic       dbg_win;

  // The port being served this cycle cannot win the next slot.
  always_comb begin
    cpu_elig = cpu_req && (state != ACC_CPU);
    dbg_elig = dbg_req && (state != ACC_DBG);
    dbg_win  = dbg_elig &&
               (!cpu_elig || (wait_cnt == WaitMax));
    cpu_win  = cpu_elig && !dbg_win;
  end

  assign cpu_stall = cpu_req & ~cpu_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rom_ce    <= 1'b0;
      rom_addr  <= 32'h0;
      cpu_ready <= 1'b0;
      dbg_ready <= 1'b0;
      cpu_inst  <= 64'h0;
      dbg_inst  <= 64'h0;
    end else begin
      cpu_ready <= (state == ACC_CPU);
      dbg_ready <= (state == ACC_DBG);
      if (state == ACC_CPU) begin
        cpu_inst <= rom_inst;
      end
      if (state == ACC_DBG) begin
        dbg_inst <= rom_inst;
      end
      unique case (1'b1)
        dbg_win: begin
          state    <= ACC_DBG;
          rom_ce   <= 1'b1;
          rom_addr <= dbg_addr;
        end
        cpu_win: begin
          state    <= ACC_CPU;
          rom_ce   <= 1'b1;
          rom_addr <= cpu_addr;
        end
        default: begin
          state  <= IDLE;
          rom_ce <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 4'h0;
    end else if (dbg_win) begin
      wait_cnt <= 4'h0;
    end else if (dbg_req && (wait_cnt != WaitMax)) begin
      wait_cnt <= wait_cnt + 4'h1;
    end
  end

endmodule

// File: tb/tb_imem_fetch_arb.sv
// Directed bench for imem_fetch_arb; a second instance with
// MAX_WAIT=1 exposes the debug priority override.
module tb_imem_fetch_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic        dbg_req = 1'b0;
  logic [31:0] dbg_addr = 32'h0;

  logic        cpu_ready_a, dbg_ready_a, cpu_stall_a, rom_ce_a;
  logic [63:0] cpu_inst_a, dbg_inst_a, rom_inst_a;
  logic [31:0] rom_addr_a;
  logic        cpu_ready_b, dbg_ready_b, cpu_stall_b, rom_ce_b;
  logic [63:0] cpu_inst_b, dbg_inst_b, rom_inst_b;
  logic [31:0] rom_addr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] romf(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a};
  endfunction

  assign rom_inst_a = romf(rom_addr_a);
  assign rom_inst_b = romf(rom_addr_b);

  imem_fetch_arb #(.MAX_WAIT(4)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready_a), .cpu_inst(cpu_inst_a),
    .cpu_stall(cpu_stall_a),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ready(dbg_ready_a), .dbg_inst(dbg_inst_a),
    .rom_ce(rom_ce_a), .rom_addr(rom_addr_a),
    .rom_inst(rom_inst_a)
  );

  imem_fetch_arb #(.MAX_WAIT(1)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready_b), .cpu_inst(cpu_inst_b),
    .cpu_stall(cpu_stall_b),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ready(dbg_ready_b), .dbg_inst(dbg_inst_b),
    .rom_ce(rom_ce_b), .rom_addr(rom_addr_b),
    .rom_inst(rom_inst_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({rom_ce_a, cpu_ready_a, dbg_ready_a, cpu_stall_a} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {rom_ce_a, cpu_ready_a, dbg_ready_a, cpu_stall_a});
    end
    checks++;
    if ({rom_addr_a, cpu_inst_a, dbg_inst_a} !== 160'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h want 0",
               rom_addr_a, cpu_inst_a, dbg_inst_a);
    end
    tick();
    tick();
    checks++;
    if (rom_ce_a !== 1'b0 || rom_ce_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_ce got %b%b want 00", rom_ce_a, rom_ce_b);
    end
    rst = 1'b1;
  endtask

  task automatic test_cpu_fetch;
    cpu_req  = 1'b1;
    cpu_addr = 32'h0;
    #1;
    checks++;
    if (cpu_stall_a !== 1'b1) begin
      errors++;
      $display("FAIL fetch_stall_pre got %b want 1", cpu_stall_a);
    end
    tick();
    checks++;
    if (rom_ce_a !== 1'b1 || rom_addr_a !== 32'h0) begin
      errors++;
      $display("FAIL fetch_e0_rom got ce=%b addr=%h want ce=1 addr=0",
               rom_ce_a, rom_addr_a);
    end
    checks++;
    if (cpu_ready_a !== 1'b0 || cpu_stall_a !== 1'b1) begin
      errors++;
      $display("FAIL fetch_e0_rdy got rdy=%b stall=%b want 0 1",
               cpu_ready_a, cpu_stall_a);
    end
    tick();
    checks++;
    if (cpu_ready_a !== 1'b1 || cpu_inst_a !== romf(32'h0)) begin
      errors++;
      $display("FAIL fetch_e1_data got rdy=%b inst=%h want 1 %h",
               cpu_ready_a, cpu_inst_a, romf(32'h0));
    end
    checks++;
    if (cpu_stall_a !== 1'b0 || rom_ce_a !== 1'b0) begin
      errors++;
      $display("FAIL fetch_e1_ctl got stall=%b ce=%b want 0 0",
               cpu_stall_a, rom_ce_a);
    end
    cpu_req = 1'b0;
    tick();
    checks++;
    if (cpu_ready_a !== 1'b0 || cpu_inst_a !== romf(32'h0)) begin
      errors++;
      $display("FAIL fetch_e2_hold got rdy=%b inst=%h want 0 %h",
               cpu_ready_a, cpu_inst_a, romf(32'h0));
    end
  endtask

  task automatic test_back_to_back;
    cpu_req  = 1'b1;
    cpu_addr = 32'h0;
    tick();
    checks++;
    if (rom_ce_a !== 1'b1 || rom_addr_a !== 32'h0) begin
      errors++;
      $display("FAIL b2b_e0 got ce=%b addr=%h want 1 0",
               rom_ce_a, rom_addr_a);
    end
    tick();
    checks++;
    if (cpu_ready_a !== 1'b1 || cpu_inst_a !== romf(32'h0)) begin
      errors++;
      $display("FAIL b2b_e1 got rdy=%b inst=%h want 1 %h",
               cpu_ready_a, cpu_inst_a, romf(32'h0));
    end
    cpu_addr = 32'h10;
    tick();
    checks++;
    if (cpu_ready_a !== 1'b0 || rom_ce_a !== 1'b1 ||
        rom_addr_a !== 32'h10) begin
      errors++;
      $display("FAIL b2b_e2 got rdy=%b ce=%b addr=%h want 0 1 10",
               cpu_ready_a, rom_ce_a, rom_addr_a);
    end
    tick();
    checks++;
    if (cpu_ready_a !== 1'b1 || cpu_inst_a !== romf(32'h10)) begin
      errors++;
      $display("FAIL b2b_e3 got rdy=%b inst=%h want 1 %h",
               cpu_ready_a, cpu_inst_a, romf(32'h10));
    end
    cpu_req = 1'b0;
    tick();
    checks++;
    if (cpu_ready_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_e4 got rdy=%b want 0", cpu_ready_a);
    end
  endtask

  task automatic test_drop_in_flight;
    cpu_req  = 1'b1;
    cpu_addr = 32'h20;
    tick();
    cpu_req = 1'b0;
    tick();
    checks++;
    if (cpu_ready_a !== 1'b1 || cpu_inst_a !== romf(32'h20)) begin
      errors++;
      $display("FAIL drop_ready got rdy=%b inst=%h want 1 %h",
               cpu_ready_a, cpu_inst_a, romf(32'h20));
    end
    tick();
  endtask

  task automatic test_alternate;
    logic [31:0] exp_addr;
    logic [1:0]  exp_rdy;
    cpu_req  = 1'b1;
    cpu_addr = 32'h100;
    dbg_req  = 1'b1;
    dbg_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_addr = (k % 2 == 0) ? 32'h100 : 32'h200;
      exp_rdy  = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01);
      checks++;
      if (rom_ce_a !== 1'b1 || rom_addr_a !== exp_addr) begin
        errors++;
        $display("FAIL alt_rom[%0d] got ce=%b addr=%h want 1 %h",
                 k, rom_ce_a, rom_addr_a, exp_addr);
      end
      checks++;
      if ({cpu_ready_a, dbg_ready_a} !== exp_rdy) begin
        errors++;
        $display("FAIL alt_rdy[%0d] got %b want %b",
                 k, {cpu_ready_a, dbg_ready_a}, exp_rdy);
      end
    end
    checks++;
    if (dbg_inst_a !== romf(32'h200) || cpu_inst_a !== romf(32'h100)) begin
      errors++;
      $display("FAIL alt_data got %h %h want %h %h",
               cpu_inst_a, dbg_inst_a, romf(32'h100), romf(32'h200));
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();
    checks++;
    if (dbg_ready_a !== 1'b1 || rom_ce_a !== 1'b0) begin
      errors++;
      $display("FAIL alt_tail got rdy=%b ce=%b want 1 0",
               dbg_ready_a, rom_ce_a);
    end
    tick();
  endtask

  task automatic test_override;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    dbg_req  = 1'b1;
    dbg_addr = 32'h300;
    tick();
    checks++;
    if (rom_addr_a !== 32'h300 || rom_addr_b !== 32'h300) begin
      errors++;
      $display("FAIL ovr_e0 got %h %h want 300 300",
               rom_addr_a, rom_addr_b);
    end
    tick();
    cpu_req  = 1'b1;
    cpu_addr = 32'h400;
    tick();
    checks++;
    if (rom_addr_a !== 32'h400) begin
      errors++;
      $display("FAIL ovr_tie_a got %h want 400", rom_addr_a);
    end
    checks++;
    if (rom_addr_b !== 32'h300 || rom_ce_b !== 1'b1) begin
      errors++;
      $display("FAIL ovr_tie_b got ce=%b addr=%h want 1 300",
               rom_ce_b, rom_addr_b);
    end
    tick();
    checks++;
    if (rom_addr_a !== 32'h300 || rom_addr_b !== 32'h400) begin
      errors++;
      $display("FAIL ovr_next got %h %h want 300 400",
               rom_addr_a, rom_addr_b);
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid;
    dbg_req  = 1'b1;
    dbg_addr = 32'h500;
    tick();
    checks++;
    if (rom_ce_a !== 1'b1 || rom_addr_a !== 32'h500) begin
      errors++;
      $display("FAIL rmid_acc got ce=%b addr=%h want 1 500",
               rom_ce_a, rom_addr_a);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({rom_ce_a, dbg_ready_a, cpu_ready_a} !== 3'b0 ||
        rom_addr_a !== 32'h0 || dbg_inst_a !== 64'h0 ||
        cpu_inst_a !== 64'h0) begin
      errors++;
      $display("FAIL rmid_clear got ce=%b rdy=%b addr=%h di=%h ci=%h",
               rom_ce_a, dbg_ready_a, rom_addr_a, dbg_inst_a, cpu_inst_a);
    end
    dbg_req = 1'b0;
    #2;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (dbg_ready_a !== 1'b0 || rom_ce_a !== 1'b0) begin
        errors++;
        $display("FAIL rmid_post[%0d] got rdy=%b ce=%b want 0 0",
                 k, dbg_ready_a, rom_ce_a);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cpu_fetch();
    test_back_to_back();
    test_drop_in_flight();
    test_alternate();
    test_override();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
